// File: rtl/uart_io_pkg.sv
// rtl/uart_io_pkg.sv - size encoding, size helpers and FSM state types for the UART I/O responder
package uart_io_pkg;

  localparam logic [1:0] SZ_1B = 2'b00;
  localparam logic [1:0] SZ_2B = 2'b01;
  localparam logic [1:0] SZ_4B = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_ISSUE,
    TX_HOLD,
    TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_COLLECT,
    RX_DONE
  } rx_state_t;

  // 2'b11 is treated as a 4-byte request, same as SZ_4B.
  function automatic logic [2:0] size_to_count(input logic [1:0] sz);
    case (sz)
      SZ_1B:   return 3'd1;
      SZ_2B:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Left-justify the used bytes so the first byte on the wire sits in [31:24].
  function automatic logic [31:0] size_align(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_1B:   return wd << 24;
      SZ_2B:   return wd << 16;
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/uart_io_responder_if.sv
// rtl/uart_io_responder_if.sv - exec-stage UART request/response bus
interface uart_io_responder_if;

  logic        uart_wenable;
  logic [1:0]  uart_wsz;
  logic [31:0] uart_wd;
  logic        uart_wdone;
  logic        uart_renable;
  logic [1:0]  uart_rsz;
  logic [31:0] uart_rd;
  logic        uart_rdone;

  modport master (
    output uart_wenable, uart_wsz, uart_wd, uart_renable, uart_rsz,
    input  uart_wdone, uart_rd, uart_rdone
  );

  modport slave (
    input  uart_wenable, uart_wsz, uart_wd, uart_renable, uart_rsz,
    output uart_wdone, uart_rd, uart_rdone
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead 8-bit sync FIFO buffering RX PHY bytes
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_io_responder.sv
// rtl/uart_io_responder.sv - serializes OUT words to the TX PHY and assembles IN words from buffered RX bytes
module uart_io_responder
  import uart_io_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_io_responder_if.slave  req,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_overflow,
  output logic                req_err
);

  tx_state_t   tx_state;
  logic [31:0] tx_shreg;
  logic [2:0]  tx_cnt;

  rx_state_t   rx_state;
  logic [31:0] rx_acc;
  logic [2:0]  rx_cnt;

  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  assign fifo_pop = (rx_state == RX_COLLECT) && !fifo_empty;

  uart_rx_fifo #(
    .DEPTH_LOG2(RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // HOLD skips one tx_busy sample because the PHY raises busy a cycle after tx_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state       <= TX_IDLE;
      tx_shreg       <= '0;
      tx_cnt         <= '0;
      tx_start       <= 1'b0;
      tx_data        <= '0;
      req.uart_wdone <= 1'b0;
    end else begin
      tx_start       <= 1'b0;
      req.uart_wdone <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (req.uart_wenable) begin
            tx_shreg <= size_align(req.uart_wsz, req.uart_wd);
            tx_cnt   <= size_to_count(req.uart_wsz);
            tx_state <= TX_LOAD;
          end
        end
        TX_LOAD, TX_ISSUE: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= tx_shreg[31:24];
            tx_shreg <= {tx_shreg[23:0], 8'h00};
            tx_cnt   <= tx_cnt - 1'b1;
            tx_state <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          tx_state <= (tx_cnt == 3'd0) ? TX_DONE : TX_ISSUE;
        end
        TX_DONE: begin
          req.uart_wdone <= 1'b1;
          tx_state       <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state       <= RX_IDLE;
      rx_acc         <= '0;
      rx_cnt         <= '0;
      req.uart_rd    <= '0;
      req.uart_rdone <= 1'b0;
    end else begin
      req.uart_rdone <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (req.uart_renable) begin
            rx_cnt   <= size_to_count(req.uart_rsz);
            rx_acc   <= '0;
            rx_state <= RX_COLLECT;
          end
        end
        RX_COLLECT: begin
          if (!fifo_empty) begin
            rx_acc <= {rx_acc[23:0], fifo_data};
            rx_cnt <= rx_cnt - 1'b1;
            if (rx_cnt == 3'd1) rx_state <= RX_DONE;
          end
        end
        RX_DONE: begin
          req.uart_rd    <= rx_acc;
          req.uart_rdone <= 1'b1;
          rx_state       <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overflow <= 1'b0;
      req_err     <= 1'b0;
    end else begin
      if (rx_valid && fifo_full && !fifo_pop) rx_overflow <= 1'b1;
      if ((req.uart_wenable && tx_state != TX_IDLE) ||
          (req.uart_renable && rx_state != RX_IDLE)) begin
        req_err <= 1'b1;
      end
    end
  end

endmodule
